// File: rtl/regdst_pkg.sv
// Shared constants for the register-destination scoreboard.
package regdst_pkg;
  localparam int NREG      = 32;
  localparam int REG_W     = 5;
  localparam int CNT_W_DEF = 2;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [NREG-1:0] onehot(input logic [REG_W-1:0] r);
    logic [NREG-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regdst_scoreboard_pending_counter.sv
// Per-register up/down counter of outstanding writes; saturates at 0, never wraps.
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_full,
  output logic o_nonzero,
  output logic o_one,
  output logic o_nz_next
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) w_cnt_nxt = '0;
    else if (i_inc && !i_dec && !o_full) w_cnt_nxt = r_cnt + 1'b1;
    else if (i_dec && !i_inc && o_nonzero) w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end

  assign o_full    = &r_cnt;
  assign o_nonzero = |r_cnt;
  assign o_one     = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});
  assign o_nz_next = |w_cnt_nxt;
endmodule

// File: rtl/regdst_scoreboard.sv
// Scoreboard of in-flight GPR writes; stalls decode on RAW hazards or a full counter.
module regdst_scoreboard
  import regdst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk_40,
  input  logic             Rst_40,
  input  logic             issue_valid_40,
  input  logic             issue_wr_40,
  input  logic [REG_W-1:0] issue_dst_40,
  input  logic [REG_W-1:0] issue_rs_40,
  input  logic [REG_W-1:0] issue_rt_40,
  input  logic             wb_valid_40,
  input  logic [REG_W-1:0] wb_dst_40,
  input  logic             flush_40,
  output logic             stall_40,
  output logic [NREG-1:0]  pending_40,
  output logic             err_40
);
  logic [NREG-1:0] w_full, w_nz, w_one, w_nz_next;
  logic [NREG-1:0] w_inc_vec, w_dec_vec;
  logic            w_wb_live, w_hz_rs, w_hz_rt, w_full_dst, w_accept;
  logic [NREG-1:0] r_pending;
  logic            r_err;

  assign w_wb_live = wb_valid_40 && (wb_dst_40 != REG_ZERO);

  // Write-first bypass: the last outstanding write lands this cycle.
  assign w_hz_rs = (issue_rs_40 != REG_ZERO) && w_nz[issue_rs_40] &&
                   !(wb_valid_40 && (wb_dst_40 == issue_rs_40) && w_one[issue_rs_40]);
  assign w_hz_rt = (issue_rt_40 != REG_ZERO) && w_nz[issue_rt_40] &&
                   !(wb_valid_40 && (wb_dst_40 == issue_rt_40) && w_one[issue_rt_40]);
  assign w_full_dst = issue_wr_40 && (issue_dst_40 != REG_ZERO) && w_full[issue_dst_40] &&
                      !(wb_valid_40 && (wb_dst_40 == issue_dst_40));

  assign stall_40 = issue_valid_40 && (w_hz_rs || w_hz_rt || w_full_dst);
  assign w_accept = issue_valid_40 && !stall_40;

  assign w_inc_vec = (w_accept && issue_wr_40 && (issue_dst_40 != REG_ZERO)) ?
                     onehot(issue_dst_40) : '0;
  assign w_dec_vec = w_wb_live ? onehot(wb_dst_40) : '0;

  assign w_full[0]    = 1'b0;
  assign w_nz[0]      = 1'b0;
  assign w_one[0]     = 1'b0;
  assign w_nz_next[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      pending_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (Clk_40),
        .rst       (Rst_40),
        .i_inc     (w_inc_vec[g]),
        .i_dec     (w_dec_vec[g]),
        .i_clr     (flush_40),
        .o_full    (w_full[g]),
        .o_nonzero (w_nz[g]),
        .o_one     (w_one[g]),
        .o_nz_next (w_nz_next[g])
      );
    end
  endgenerate

  always_ff @(posedge Clk_40) begin
    if (Rst_40) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_nz_next;
      if (w_wb_live && !w_nz[wb_dst_40]) r_err <= 1'b1;
    end
  end

  assign pending_40 = r_pending;
  assign err_40     = r_err;
endmodule

// File: tb/tb_regdst_scoreboard.sv
// Directed self-checking bench for regdst_scoreboard (CNT_W=2).
module tb_regdst_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        iv, iw, wv, fl;
  logic [4:0]  idst, irs, irt, wdst;
  logic        stall, err;
  logic [31:0] pend;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  regdst_scoreboard #(.CNT_W(2)) dut (
    .Clk_40(clk), .Rst_40(rst),
    .issue_valid_40(iv), .issue_wr_40(iw), .issue_dst_40(idst),
    .issue_rs_40(irs), .issue_rt_40(irt),
    .wb_valid_40(wv), .wb_dst_40(wdst), .flush_40(fl),
    .stall_40(stall), .pending_40(pend), .err_40(err)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    iv = 0; iw = 0; idst = 0; irs = 0; irt = 0; wv = 0; wdst = 0; fl = 0;
  endtask

  task automatic issue(input logic w, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    iv = 1; iw = w; idst = d; irs = s; irt = t;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    issue(1, 5'd4, 0, 0);
    step(); step();
    idle(); #1;
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL reset_pending got=%h exp=%h", pend, 32'h0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst = 0; step();
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL reset_held_issue got=%h exp=0", pend); end
  endtask

  task automatic test_raw_and_bypass();
    issue(1, 5'd8, 0, 0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue8_stall got=%b exp=0", stall); end
    step(); idle();
    checks++; if (pend !== 32'h0000_0100) begin errors++; $display("FAIL issue8_pending got=%h exp=%h", pend, 32'h100); end
    issue(0, 0, 5'd8, 0); #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs8_stall cyc=%0d got=%b exp=1", i, stall); end
      step();
    end
    checks++; if (pend !== 32'h0000_0100) begin errors++; $display("FAIL stalled_no_change got=%h exp=%h", pend, 32'h100); end
    wv = 1; wdst = 5'd8; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall got=%b exp=0", stall); end
    step(); idle();
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL bypass_pending got=%h exp=0", pend); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bypass_err got=%b exp=0", err); end
  endtask

  task automatic test_back_to_back();
    issue(1, 5'd12, 0, 0); step();
    issue(0, 0, 0, 5'd12); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_rt_stall got=%b exp=1", stall); end
    idle(); wv = 1; wdst = 5'd12; step(); idle();
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL b2b_drain got=%h exp=0", pend); end
  endtask

  task automatic test_reg0();
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reg0_stall i=%0d got=%b exp=0", i, stall); end
      step();
      checks++; if (pend !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL reg0_state i=%0d pend=%h err=%b exp=0/0", i, pend, err); end
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      issue(1, 5'd5, 0, 0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_fill i=%0d got=%b exp=0", i, stall); end
      step();
    end
    issue(1, 5'd5, 0, 0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_full_stall got=%b exp=1", stall); end
    wv = 1; wdst = 5'd5; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_wb_accept got=%b exp=0", stall); end
    step(); idle();
    // count must still be 3: an rt reader with a same-cycle wb is not bypassed
    issue(0, 0, 0, 5'd5); wv = 1; wdst = 5'd5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_cnt3_rt got=%b exp=1", stall); end
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (pend !== 32'h0000_0020) begin errors++; $display("FAIL sat_drain i=%0d got=%h exp=%h", i, pend, 32'h20); end
      wv = 1; wdst = 5'd5; step();
    end
    idle();
    checks++; if (pend !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sat_empty pend=%h err=%b exp=0/0", pend, err); end
  endtask

  task automatic test_err_flush();
    wv = 1; wdst = 5'd9; step(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL err_cnt0 got=%h exp=0", pend); end
    issue(1, 5'd3, 0, 0); step();
    issue(1, 5'd7, 0, 0); step(); idle();
    checks++; if (pend !== 32'h0000_0088) begin errors++; $display("FAIL flush_pre got=%h exp=%h", pend, 32'h88); end
    fl = 1; issue(1, 5'd4, 0, 0); step(); idle();
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL flush_pending got=%h exp=0", pend); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err_kept got=%b exp=1", err); end
    issue(0, 0, 5'd3, 5'd7); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_no_stall got=%b exp=0", stall); end
    idle(); rst = 1; step(); rst = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err_clear got=%b exp=0", err); end
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_raw_and_bypass();
    test_back_to_back();
    test_reg0();
    test_saturation();
    test_err_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
